// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types and widths
package cpu_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush
module fetch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding imem fetch, decode handoff buffer
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INST_W   = cpu_pkg::INST_W,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int E_W   = PC_W + INST_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   fetch_pc, req_pc;
    logic [E_W-1:0]    head, hold_q;
    logic              accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign imem_addr  = fetch_pc;
    assign imem_req   = reset && (state_q == S_IDLE) && !redirect_valid && !fifo_full;
    assign accept     = imem_req && imem_ready;
    assign push       = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    assign inst_valid = reset && (fifo_count != '0);
    assign pop        = inst_valid && inst_ready;

    // Empty buffer keeps presenting the last head so decode sees stable data.
    assign {inst_pc, inst_data} = fifo_empty ? hold_q : head;

    fetch_fifo #(.W(E_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({req_pc, imem_rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)         state_d = S_IDLE;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP: if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            hold_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid)  fetch_pc <= redirect_pc;
            else if (accept)     fetch_pc <= fetch_pc + PC_W'(1);
            if (accept)          req_pc   <= fetch_pc;
            if (!fifo_empty)     hold_q   <= head;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;

    int total = 0;
    int bad   = 0;
    int lat   = 1;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction

    // Memory: one response per accepted request, lat cycles later.
    initial begin
        logic       acc;
        logic [7:0] acc_addr, pend_addr;
        int         cnt;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        cnt = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (acc) begin
                pend_addr = acc_addr;
                cnt = lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(pend_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_inst(input logic [7:0] pc);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (inst_valid && inst_ready) begin
                check("inst_pc", 40'(inst_pc), 40'(pc));
                check("inst_data", 40'(inst_data), 40'(word(pc)));
                got = 1;
            end
            tick();
        end
        check("inst_timeout", 40'(got), 40'd1);
    endtask

    task automatic wait_req();
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (imem_req) got = 1;
            else tick();
        end
        check("req_timeout", 40'(got), 40'd1);
    endtask

    task automatic wait_flag(input string tag, input bit use_rvalid);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (use_rvalid ? imem_rvalid : inst_valid) got = 1;
            else tick();
        end
        check(tag, 40'(got), 40'd1);
    endtask

    initial begin
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_ready = 1'b1;
        inst_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_req", 40'(imem_req), 40'd0);
        check("rst_valid", 40'(inst_valid), 40'd0);
        check("rst_data", 40'(inst_data), 40'd0);
        check("rst_pc", 40'(inst_pc), 40'd0);

        // free run
        reset = 1'b1;
        #1;
        check("first_req", 40'(imem_req), 40'd1);
        check("first_addr", 40'(imem_addr), 40'h00);
        for (int i = 0; i < 4; i++) wait_inst(8'(i));

        // backpressure from a fresh reset
        reset = 1'b0;
        inst_ready = 1'b0;
        tick(); tick();
        check("rst2_valid", 40'(inst_valid), 40'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_req", 40'(imem_req), 40'd0);
        check("bp_valid", 40'(inst_valid), 40'd1);
        check("bp_pc", 40'(inst_pc), 40'h00);
        tick(); tick(); tick();
        check("bp_req_hold", 40'(imem_req), 40'd0);
        check("bp_pc_hold", 40'(inst_pc), 40'h00);
        check("bp_data_hold", 40'(inst_data), 40'(word(8'h00)));
        inst_ready = 1'b1;
        wait_inst(8'h00);
        check("resume_req", 40'(imem_req), 40'd1);
        check("resume_addr", 40'(imem_addr), 40'h02);
        wait_inst(8'h01);
        wait_inst(8'h02);

        // redirect while a 3-cycle request is outstanding
        lat = 3;
        wait_req();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("redir_req_forced", 40'(imem_req), 40'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drop_valid", 40'(inst_valid), 40'd0);
        check("drop_req", 40'(imem_req), 40'd0);
        wait_req();
        check("redir_addr", 40'(imem_addr), 40'h40);
        wait_inst(8'h40);
        wait_inst(8'h41);
        wait_inst(8'h42);

        // redirect coincident with rvalid and a decode handshake
        inst_ready = 1'b0;
        wait_flag("head_timeout", 1'b0);
        check("coin_head", 40'(inst_pc), 40'h43);
        wait_flag("rvalid_timeout", 1'b1);
        check("coin_valid", 40'(inst_valid), 40'd1);
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("coin_flushed", 40'(inst_valid), 40'd0);
        check("coin_req", 40'(imem_req), 40'd1);
        check("coin_addr", 40'(imem_addr), 40'h80);
        wait_inst(8'h80);
        wait_inst(8'h81);

        // wrap around the top of the address space
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        wait_inst(8'hFE);
        wait_inst(8'hFF);
        wait_inst(8'h00);
        wait_inst(8'h01);

        // reset while dropping, late response arrives after reset
        lat = 4;
        wait_req();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h20;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rdrop_req", 40'(imem_req), 40'd0);
        reset = 1'b0;
        imem_ready = 1'b0;
        tick();
        check("rdrop_rst_req", 40'(imem_req), 40'd0);
        check("rdrop_rst_valid", 40'(inst_valid), 40'd0);
        tick();
        reset = 1'b1;
        #1;
        check("late_req", 40'(imem_req), 40'd1);
        check("late_addr", 40'(imem_addr), 40'h00);
        tick();
        check("late_ignored", 40'(inst_valid), 40'd0);
        tick(); tick();
        check("late_ignored2", 40'(inst_valid), 40'd0);
        check("late_addr2", 40'(imem_addr), 40'h00);
        lat = 1;
        imem_ready = 1'b1;
        wait_inst(8'h00);
        wait_inst(8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that owns the architectural PC and issues sequential reads to instruction memory.
- Buffers returned instructions in a small FIFO and hands {pc, instruction} to decode over a valid/ready handshake.
- Consumes the branch stage's resolved target (new_pc) as a redirect, flushing wrong-path work.
- Sits directly upstream of decode/execute, and downstream of the branch resolution logic for its redirect input.

Parameters:
- PC_W, 8, PC and instruction-address width.
- INST_W, 32, instruction word width.
- DEPTH, 2, instruction buffer entries; must be at least 2.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- redirect_valid  in  1  branch stage supplies a non-sequential target this cycle.
- redirect_pc  in  PC_W  redirect target (branch stage new_pc).
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address.
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid; arrives 1 or more cycles after acceptance.
- imem_rdata  in  INST_W  fetched instruction.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode accepts the head when inst_valid && inst_ready.
- inst_data  out  INST_W  head instruction.
- inst_pc  out  PC_W  address of the head instruction.

Behaviour:
- Reset: while reset=0 at a rising edge, all state is cleared as follows:
  - fetch_pc <= RESET_PC, FIFO emptied, state <= S_IDLE.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
  - A reset mid-fetch abandons the outstanding request; any later rvalid is ignored while state is S_IDLE.
- First request: imem_req rises in the first cycle after reset returns to 1, with imem_addr=RESET_PC.
- Only one request may be outstanding. States:
  - S_IDLE, no request outstanding:
    - imem_req = !redirect_valid && (count < DEPTH).
    - On acceptance, go to S_WAIT and set fetch_pc <= fetch_pc+1.
  - S_WAIT, one request outstanding; imem_req=0.
    - On rvalid, push {pc_of_req, rdata} and go to S_IDLE.
    - The FIFO is guaranteed to have a free slot, because a request issues only when count < DEPTH.
  - S_DROP, outstanding request is wrong-path; imem_req=0.
    - On rvalid, discard the data and go to S_IDLE.
- imem_req and imem_addr stay stable until accepted (imem_addr = fetch_pc).
- PC increment is modulo 2^PC_W: 8'hFF wraps to 8'h00.
- Redirect (redirect_valid=1) at the clock edge:
  - fetch_pc <= redirect_pc and the FIFO is flushed (count <= 0).
  - In S_WAIT, go to S_DROP unless rvalid arrives in the same cycle; that response is dropped and the state goes to S_IDLE.
  - In S_DROP, stay in S_DROP unless rvalid arrives in the same cycle, in which case go to S_IDLE.
  - imem_req is forced to 0 in the redirect cycle; the first request for the target issues the following cycle.
  - A redirect has priority over a push, over the decode pop and over the PC increment.
  - A decode handshake completing in the redirect cycle is still counted as consumed by decode.
- Decode output:
  - inst_valid = (count != 0); inst_data and inst_pc come from the FIFO head and are held stable while inst_valid && !inst_ready.
  - When the buffer is empty, inst_data and inst_pc hold their last value.
- Push and pop in the same cycle leave count unchanged and keep ordering.
- Throughput: 1 instruction per 2 cycles with single-cycle memory. Redirect-to-first-valid latency is 3 cycles with 1-cycle memory.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W, INST_W and RESET_PC.
  - The fetch_state_t enum {S_IDLE, S_WAIT, S_DROP}.
  - A fetch_entry_t struct {pc, inst}, also used by decode.
- Sub-module fetch_fifo: a synchronous FIFO with DEPTH entries and ports push, pop, flush, full, empty and count. Flush has priority over push.

Test Plan:
- Reset then free-run, with imem_ready=1, 1-cycle rvalid and inst_ready=1:
  - Fetch addresses go 00,01,02,… and inst_pc matches.
  - Output during reset is imem_req=0 and inst_valid=0.
- Backpressure: hold inst_ready=0.
  - After 2 instructions, imem_req stays 0 and head inst_pc=00 is held stable.
  - Releasing inst_ready resumes fetch at 02.
- Redirect while in S_WAIT, with redirect_pc=8'h40 and memory latency 3:
  - The stale response is discarded.
  - The next imem_addr is 40 and the first delivered inst_pc is 40.
- Redirect coincident with rvalid and with an inst handshake:
  - The arriving data is dropped and the FIFO is emptied.
  - The consumed instruction is not re-delivered.
- Wrap: redirect to 8'hFE.
  - Delivered inst_pc sequence is FE, FF, 00, 01.
- Reset asserted while in S_DROP, with a late rvalid:
  - The late response is ignored.
  - After reset, the first imem_addr is RESET_PC (00).
